// File: rtl/rr_sel_arbiter_pkg.sv
// rr_sel_pkg: shared types and constants for the round-robin select arbiter.
//   state_e   : arbiter FSM state (IDLE, GRANT)
//   NUM_SRC   : number of requesting sources (4)
//   SEL_W     : width of the binary mux select (2)
//   CNT_W     : width of each per-source grant statistics counter (8)
//   onehot()  : binary index -> one-hot grant vector
package rr_sel_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request/grant bundle between the sources and the arbiter.
//   req       : per-source request, bit i selects mux input i
//   done      : single-cycle release pulse from the current owner
//   gnt       : registered one-hot grant
//   sel       : binary index of gnt, drives the 4:1 mux select
//   gnt_valid : high while a grant is held
//   grant_cnt : four 8-bit per-source grant counters, only present when
//               RR_SEL_ARB_STATS_EN is defined
// Modports: master = request side, slave = arbiter side.
interface rr_sel_arbiter_if;
  import rr_sel_pkg::*;

  logic [NUM_SRC-1:0]       req;
  logic                     done;
  logic [NUM_SRC-1:0]       gnt;
  logic [SEL_W-1:0]         sel;
  logic                     gnt_valid;
`ifdef RR_SEL_ARB_STATS_EN
  logic [NUM_SRC*CNT_W-1:0] grant_cnt;
`endif

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  gnt_valid
`ifdef RR_SEL_ARB_STATS_EN
    , input grant_cnt
`endif
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output gnt_valid
`ifdef RR_SEL_ARB_STATS_EN
    , output grant_cnt
`endif
  );

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req  : request vector
//   last : index of the previous owner; search starts at (last+1) mod 4
//   idx  : index of the first set request found cyclically
//   any  : at least one request is set
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // 2-bit addition wraps naturally, giving the cyclic search order.
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last + SEL_W'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: 4-source round-robin arbiter whose grant index directly
// drives a 4:1 mux select.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : rr_sel_arbiter_if.slave (req, done in; gnt, sel, gnt_valid
//              and optionally grant_cnt out)
// Parameter HOLD_MAX: cycles a grant may be held before forced release
// (0 = unlimited).
// Optional feature macro RR_SEL_ARB_STATS_EN: adds saturating per-source
// grant counters on bus.grant_cnt.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_sel_arbiter_if.slave bus
);

  localparam int HOLD_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               gv_q, gv_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               hold_hit;
  logic               release_grant;
  logic               grant_evt;

  rr_pick u_pick (
    .req  (bus.req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // sel_q doubles as the owner index while in GRANT.
  assign hold_hit      = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
  assign release_grant = bus.done || !bus.req[sel_q] || hold_hit;
  assign grant_evt     = (state_q == IDLE) && pick_any;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)      state_d = GRANT;
      GRANT:   if (release_grant) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output / datapath next values; all outputs are registered below.
  always_comb begin
    gnt_d  = gnt_q;
    sel_d  = sel_q;
    gv_d   = gv_q;
    last_d = last_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        gv_d  = 1'b0;
        if (pick_any) begin
          gnt_d  = onehot(pick_idx);
          sel_d  = pick_idx;
          gv_d   = 1'b1;
          hold_d = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          last_d = sel_q;
          gnt_d  = '0;
          gv_d   = 1'b0;
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          // Saturate rather than wrap so an unlimited hold never aliases.
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
        gv_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      sel_q  <= '0;
      gv_q   <= 1'b0;
      last_q <= SEL_W'(NUM_SRC - 1);
      hold_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      sel_q  <= sel_d;
      gv_q   <= gv_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.gnt_valid = gv_q;

`ifdef RR_SEL_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_SRC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else if (grant_evt && (cnt_q[pick_idx] != {CNT_W{1'b1}})) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_out
    assign bus.grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  logic unused_evt;
  assign unused_evt = grant_evt;
`endif

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed testbench for rr_sel_arbiter: one instance at the default
// HOLD_MAX=16 and one at HOLD_MAX=4, sharing clock and reset.
module tb_rr_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rr_sel_arbiter_if bus ();
  rr_sel_arbiter_if bus4 ();

  rr_sel_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rr_sel_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // 4:1 mux driven by sel with inputs a=0, b=1, c=0, d=1.
  logic mux_o;
  always_comb begin
    mux_o = 1'b0;
    case (bus.sel)
      2'd0: mux_o = 1'b0;
      2'd1: mux_o = 1'b1;
      2'd2: mux_o = 1'b0;
      2'd3: mux_o = 1'b1;
      default: mux_o = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic [3:0]  exp_gnt;
    logic [5:0]  exp_gv4;
    logic [3:0]  mux_pat;

    rst_n     = 1'b1;
    bus.req   = '0;
    bus.done  = 1'b0;
    bus4.req  = '0;
    bus4.done = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_gv",  32'(bus.gnt_valid), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_req_gv", 32'(bus.gnt_valid), 32'h0);

    // Round-robin with all sources requesting, done two cycles after grant
    bus.req = 4'b1111;
    mux_pat = 4'b1010;
    for (int g = 0; g < 5; g++) begin
      exp_gnt = 4'b0001 << (g % 4);
      step();
      chk($sformatf("rr_gnt%0d", g), 32'(bus.gnt), 32'(exp_gnt));
      chk($sformatf("rr_sel%0d", g), 32'(bus.sel), 32'(g % 4));
      chk($sformatf("rr_gv%0d", g),  32'(bus.gnt_valid), 32'h1);
      chk($sformatf("rr_mux%0d", g), 32'(mux_o), 32'(mux_pat[g % 4]));
      step();
      chk($sformatf("rr_hold%0d", g), 32'(bus.gnt), 32'(exp_gnt));
      bus.done = 1'b1;
      if (g == 4) bus.req = 4'b0000;
      step();
      chk($sformatf("rr_bubble_gnt%0d", g), 32'(bus.gnt), 32'h0);
      chk($sformatf("rr_bubble_gv%0d", g),  32'(bus.gnt_valid), 32'h0);
      bus.done = 1'b0;
    end

    // Single requester on source 2; other bits cannot steal an active grant
    bus.req = 4'b0100;
    step();
    chk("c_gnt", 32'(bus.gnt), 32'h4);
    chk("c_sel", 32'(bus.sel), 32'h2);
    bus.req = 4'b1111;
    bus.req[2] = 1'b1;
    step();
    chk("c_keep_gnt", 32'(bus.gnt), 32'h4);
    chk("c_keep_sel", 32'(bus.sel), 32'h2);
    bus.req = 4'b0000;
    step();
    chk("c_drop_gnt", 32'(bus.gnt), 32'h0);
    chk("c_drop_gv",  32'(bus.gnt_valid), 32'h0);
    chk("c_drop_sel_held", 32'(bus.sel), 32'h2);
    bus.done = 1'b1;
    step();
    chk("idle_done_ignored", 32'(bus.gnt_valid), 32'h0);
    bus.done = 1'b0;

    // Asynchronous reset in the middle of a grant to source 2
    bus.req = 4'b0100;
    step();
    chk("r_pre_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_gnt", 32'(bus.gnt), 32'h0);
    chk("r_async_sel", 32'(bus.sel), 32'h0);
    chk("r_async_gv",  32'(bus.gnt_valid), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("r_first_gnt", 32'(bus.gnt), 32'h1);
    chk("r_first_sel", 32'(bus.sel), 32'h0);

    // done together with owner dropping req is one release
    bus.done = 1'b1;
    bus.req  = 4'b1110;
    step();
    chk("dd_rel_gv", 32'(bus.gnt_valid), 32'h0);
    bus.done = 1'b0;
    step();
    chk("dd_next_gnt", 32'(bus.gnt), 32'h2);

    // Forced release after HOLD_MAX=16 cycles, then rotation moves on
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.gnt_valid !== 1'b1) break;
      n++;
    end
    chk("hold16_len", 32'(n), 32'd16);
    step();
    chk("hold16_next_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    step();

    // HOLD_MAX=4: 4 cycles high, 1 low, re-grant to source 0
    bus4.req = 4'b0001;
    exp_gv4  = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("hold4_gv%0d", i), 32'(bus4.gnt_valid), 32'(exp_gv4[i]));
    end
    chk("hold4_regnt", 32'(bus4.gnt), 32'h1);
    bus4.req = 4'b0000;

`ifdef RR_SEL_ARB_STATS_EN
    // Grant counters: 300 grants to source 1 saturate counter 1 only
    rst_n = 1'b0;
    step();
    chk("st_rst", bus.grant_cnt, 32'h0);
    rst_n    = 1'b1;
    bus.req  = 4'b0010;
    bus.done = 1'b1;
    repeat (20) step();
    chk("st_cnt10", bus.grant_cnt, 32'h0000_0A00);
    repeat (580) step();
    chk("st_sat", bus.grant_cnt, 32'h0000_FF00);
    bus.req  = 4'b0000;
    bus.done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
